// File: rtl/kyber_pkg.sv
// Shared constants and types for the Kyber coefficient arithmetic path.
package kyber_pkg;

  localparam logic [11:0] KYBER_Q       = 12'd3329;
  localparam logic [12:0] BARRETT_M     = 13'd5039;
  localparam int unsigned BARRETT_SHIFT = 24;

  typedef logic [11:0] coeff_t;
  typedef logic [23:0] prod_t;
  typedef logic [13:0] red_t;

  // Brings a Barrett remainder in [0, 3q) down to [0, q).
  function automatic coeff_t cond_sub2(input red_t r);
    red_t x;
    x = r;
    if (x >= red_t'(KYBER_Q)) x = x - red_t'(KYBER_Q);
    if (x >= red_t'(KYBER_Q)) x = x - red_t'(KYBER_Q);
    return coeff_t'(x);
  endfunction

endpackage

// File: rtl/kyber_barrett_red.sv
// Combinational Barrett reduction of a 24-bit product to a 14-bit remainder in [0, 3q).
module kyber_barrett_red
  import kyber_pkg::*;
(
  input  prod_t p,
  output red_t  r
);

  logic [36:0] pm;
  logic [12:0] t;
  prod_t       tq;

  // The estimate t undershoots floor(p/q) by at most 2, so p - t*q < 3q fits in 14 bits.
  always_comb begin
    pm = 37'(p) * 37'(BARRETT_M);
    t  = 13'(pm >> BARRETT_SHIFT);
    tq = prod_t'(t) * prod_t'(KYBER_Q);
    r  = red_t'(p - tq);
  end

endmodule

// File: rtl/kyber_mulred_pipe.sv
// Three-stage elastic modular multiplier: multiply, Barrett reduce, final correction.
module kyber_mulred_pipe
  import kyber_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [11:0]      a_i,
  input  logic [11:0]      b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [11:0]      result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);

  logic             s1_valid, s2_valid, s3_valid;
  prod_t            s1_p;
  red_t             s2_r;
  coeff_t           s3_res;
  logic [TAG_W-1:0] s1_tag, s2_tag, s3_tag;
  logic             ld1, ld2, ld3;
  red_t             red;

  kyber_barrett_red u_red (
    .p (s1_p),
    .r (red)
  );

  // A stage advances when it is empty or its successor advances, so bubbles collapse.
  always_comb begin
    ld3 = out_ready_i | ~s3_valid;
    ld2 = ~s2_valid | ld3;
    ld1 = ~s1_valid | ld2;
  end

  always_comb begin
    in_ready_o  = ld1;
    out_valid_o = s3_valid;
    result_o    = s3_res;
    tag_o       = s3_tag;
    busy_o      = s1_valid | s2_valid | s3_valid;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s1_p     <= '0;
      s2_r     <= '0;
      s3_res   <= '0;
      s1_tag   <= '0;
      s2_tag   <= '0;
      s3_tag   <= '0;
    end else begin
      if (ld1) begin
        s1_valid <= in_valid_i;
        if (in_valid_i) begin
          s1_p   <= prod_t'(a_i) * prod_t'(b_i);
          s1_tag <= tag_i;
        end
      end
      if (ld2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_r   <= red;
          s2_tag <= s1_tag;
        end
      end
      // Data only moves with a valid entry, keeping the output stable once consumed.
      if (ld3) begin
        s3_valid <= s2_valid;
        if (s2_valid) begin
          s3_res <= cond_sub2(s2_r);
          s3_tag <= s2_tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_kyber_mulred_pipe.sv
// Directed and random self-checking bench for the Kyber modular multiplier pipeline.
module tb_kyber_mulred_pipe;

  localparam int unsigned TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [11:0]      a = '0;
  logic [11:0]      b = '0;
  logic [TAG_W-1:0] tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [11:0]      result;
  logic [TAG_W-1:0] tag_out;
  logic             busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  kyber_mulred_pipe #(.TAG_W(TAG_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .tag_i       (tag),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .tag_o       (tag_out),
    .busy_o      (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (result !== 12'd0) begin errors++; $display("FAIL reset_result: got %0d want 0", result); end
    checks++; if (tag_out !== 4'd0) begin errors++; $display("FAIL reset_tag: got %0d want 0", tag_out); end
  endtask

  task automatic test_corner_values();
    logic [11:0] va [8];
    logic [11:0] vb [8];
    logic [11:0] ve [8];
    logic [3:0]  vt [8];
    va = '{12'd3328, 12'd4095, 12'd0,    12'd1,    12'd17,  12'd3329, 12'd2,    12'd3328};
    vb = '{12'd3328, 12'd4095, 12'd4095, 12'd3328, 12'd17,  12'd1,    12'd1665, 12'd2};
    ve = '{12'd1,    12'd852,  12'd0,    12'd3328, 12'd289, 12'd0,    12'd1,    12'd3327};
    vt = '{4'd5, 4'd10, 4'd3, 4'd12, 4'd15, 4'd7, 4'd9, 4'd1};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; a = va[i]; b = vb[i]; tag = vt[i];
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL corner_in_ready[%0d]: got %b want 1", i, in_ready); end
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL corner_early1[%0d]: got %b want 0", i, out_valid); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL corner_early2[%0d]: got %b want 0", i, out_valid); end
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL corner_valid[%0d]: got %b want 1", i, out_valid); end
      checks++; if (result !== ve[i]) begin errors++; $display("FAIL corner_result[%0d]: got %0d want %0d", i, result, ve[i]); end
      checks++; if (tag_out !== vt[i]) begin errors++; $display("FAIL corner_tag[%0d]: got %0d want %0d", i, tag_out, vt[i]); end
      step();
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL corner_drain[%0d]: got valid=%b busy=%b want 0 0", i, out_valid, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned pa [8];
    int unsigned pb [8];
    int unsigned pe [8];
    for (int i = 0; i < 8; i++) begin
      pa[i] = i * 517 + 3;
      pb[i] = 4095 - i * 311;
      pe[i] = (pa[i] * pb[i]) % 3329;
    end
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        in_valid = 1'b1; a = 12'(pa[c]); b = 12'(pb[c]); tag = 4'(c);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c < 8) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", c, in_ready); end
      end
      step();
      checks++; if (out_valid !== (c >= 2 && c < 10)) begin
        errors++; $display("FAIL b2b_valid[%0d]: got %b want %b", c, out_valid, (c >= 2 && c < 10));
      end
      if (c >= 2 && c < 10) begin
        checks++; if (result !== 12'(pe[c-2])) begin errors++; $display("FAIL b2b_result[%0d]: got %0d want %0d", c, result, pe[c-2]); end
        checks++; if (tag_out !== 4'(c-2)) begin errors++; $display("FAIL b2b_tag[%0d]: got %0d want %0d", c, tag_out, c-2); end
      end
    end
  endtask

  task automatic test_stall();
    int unsigned pa [4];
    int unsigned pb [4];
    int unsigned pe [4];
    logic [3:0]  pt [4];
    int idx;
    int n;
    logic sent;
    pa = '{1000, 2000, 3000, 4000};
    pb = '{4000, 3000, 2000, 1000};
    pt = '{4'd2, 4'd4, 4'd6, 4'd8};
    for (int i = 0; i < 4; i++) pe[i] = (pa[i] * pb[i]) % 3329;
    out_ready = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      in_valid = 1'b1; a = 12'(pa[idx]); b = 12'(pb[idx]); tag = pt[idx];
      #1;
      checks++; if (in_ready !== (cyc < 3)) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b want %b", cyc, in_ready, (cyc < 3)); end
      if (in_ready === 1'b1 && idx < 3) idx++;
      step();
      if (cyc >= 2) begin
        checks++; if (out_valid !== 1'b1 || result !== 12'(pe[0]) || tag_out !== pt[0]) begin
          errors++; $display("FAIL stall_hold[%0d]: got v=%b r=%0d t=%0d want v=1 r=%0d t=%0d", cyc, out_valid, result, tag_out, pe[0], pt[0]);
        end
      end
    end
    out_ready = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      if (out_valid === 1'b1) begin
        checks++;
        if (n >= 4) begin
          errors++; $display("FAIL stall_extra: got extra result %0d tag %0d want none", result, tag_out);
        end else if (result !== 12'(pe[n]) || tag_out !== pt[n]) begin
          errors++; $display("FAIL stall_order[%0d]: got r=%0d t=%0d want r=%0d t=%0d", n, result, tag_out, pe[n], pt[n]);
        end
        n++;
      end
      sent = in_valid && in_ready;
      step();
      if (sent) in_valid = 1'b0;
    end
    checks++; if (n != 4) begin errors++; $display("FAIL stall_count: got %0d results want 4", n); end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stall_empty: got v=%b busy=%b want 0 0", out_valid, busy); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 12'(100 + i); b = 12'(200 + i); tag = 4'(11 + i);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready[%0d]: got %b want 1", i, in_ready); end
      step();
    end
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_full: got busy=%b v=%b want 1 1", busy, out_valid); end
    rst = 1'b1; out_ready = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
    checks++; if (result !== 12'd0 || tag_out !== 4'd0) begin errors++; $display("FAIL rstmid_data: got r=%0d t=%0d want 0 0", result, tag_out); end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_stale[%0d]: got v=%b busy=%b want 0 0", i, out_valid, busy); end
    end
  endtask

  task automatic test_random();
    int unsigned exp_res_q [$];
    int unsigned exp_tag_q [$];
    int unsigned er, et, ai, bi;
    logic        prev_stall;
    logic [11:0] prev_res;
    logic [3:0]  prev_tag;
    prev_stall = 1'b0; prev_res = '0; prev_tag = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      checks++; if (busy !== (exp_res_q.size() != 0)) begin errors++; $display("FAIL rand_busy[%0d]: got %b want %b", cyc, busy, (exp_res_q.size() != 0)); end
      if (prev_stall) begin
        checks++; if (out_valid !== 1'b1 || result !== prev_res || tag_out !== prev_tag) begin
          errors++; $display("FAIL rand_stable[%0d]: got v=%b r=%0d t=%0d want v=1 r=%0d t=%0d", cyc, out_valid, result, tag_out, prev_res, prev_tag);
        end
      end
      out_ready = ($urandom_range(0, 99) < 70);
      in_valid  = ($urandom_range(0, 99) < 70);
      ai = $urandom_range(0, 4095); bi = $urandom_range(0, 4095);
      a = 12'(ai); b = 12'(bi); tag = 4'($urandom_range(0, 15));
      #1;
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_res_q.size() == 0) begin
          errors++; $display("FAIL rand_spurious[%0d]: got r=%0d t=%0d want no result", cyc, result, tag_out);
        end else begin
          er = exp_res_q.pop_front(); et = exp_tag_q.pop_front();
          if (result !== 12'(er) || tag_out !== 4'(et)) begin
            errors++; $display("FAIL rand_result[%0d]: got r=%0d t=%0d want r=%0d t=%0d", cyc, result, tag_out, er, et);
          end
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        exp_res_q.push_back((ai * bi) % 3329);
        exp_tag_q.push_back(int'(tag));
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_res = result; prev_tag = tag_out;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      if (out_valid === 1'b1) begin
        checks++;
        if (exp_res_q.size() == 0) begin
          errors++; $display("FAIL drain_spurious[%0d]: got r=%0d want no result", cyc, result);
        end else begin
          er = exp_res_q.pop_front(); et = exp_tag_q.pop_front();
          if (result !== 12'(er) || tag_out !== 4'(et)) begin
            errors++; $display("FAIL drain_result[%0d]: got r=%0d t=%0d want r=%0d t=%0d", cyc, result, tag_out, er, et);
          end
        end
      end
      step();
    end
    checks++; if (exp_res_q.size() != 0) begin errors++; $display("FAIL rand_lost: got %0d results missing want 0", exp_res_q.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_idle: got busy=%b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_corner_values();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
